// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer slice.
// The ROB payload record, the default depth and the index type live here
// so Dispatch, retire and the ROB all agree on one definition.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEFAULT = 16;
    localparam int ROB_IDX_W_DEFAULT = $clog2(ROB_DEPTH_DEFAULT);

    typedef logic [ROB_IDX_W_DEFAULT-1:0] rob_idx_t;

    // Payload carried from Dispatch to retire; the ROB never inspects it.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest_reg;
        logic [6:0]  opcode;
        logic [7:0]  tag;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch/writeback/retire interface of the reorder buffer.
// master = the pipeline around the ROB (Dispatch, writeback, retire);
// slave  = the ROB itself.
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
);
    localparam int IDX_W = $clog2(ROB_DEPTH);

    // Dispatch side
    logic             entry_valid;
    rob_entry_t       new_entry;
    logic [IDX_W-1:0] rob_index;
    logic             rob_full;

    // Writeback side
    logic             wb_valid;
    logic [IDX_W-1:0] wb_index;
    logic             wb_exception;

    // Retire side
    logic             commit_ready;
    logic             commit_valid;
    rob_entry_t       commit_entry;
    logic [IDX_W-1:0] commit_index;
    logic             commit_exception;

    // Pipeline flush
    logic             flush;

    modport master (
        output entry_valid, new_entry, wb_valid, wb_index, wb_exception,
               commit_ready, flush,
        input  rob_index, rob_full, commit_valid, commit_entry,
               commit_index, commit_exception
    );

    modport slave (
        input  entry_valid, new_entry, wb_valid, wb_index, wb_exception,
               commit_ready, flush,
        output rob_index, rob_full, commit_valid, commit_entry,
               commit_index, commit_exception
    );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Circular pointer with an extra wrap bit above the index.
// Equal pointers mean empty; same index with differing wrap bit means full.
module reorder_buffer_rob_ptr #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W:0]   ptr
);

    // Pointer register: clear on reset or flush, otherwise advance on inc.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            // Natural overflow of the top bit toggles the wrap bit.
            ptr <= ptr + (IDX_W+1)'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between Dispatch and retire.
// Allocates one entry per cycle at tail, marks entries complete from
// writeback, retires one per cycle at head; flush empties it.
// Optional feature: define ROB_STATS_EN to add saturating 32-bit
// stat_full_cycles / stat_commits counters (cleared by rst only).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    reorder_buffer_if.slave      rob_if
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]          stat_full_cycles,
    output logic [31:0]          stat_commits
`endif
);

    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

    logic [ROB_IDX_W:0]   head;
    logic [ROB_IDX_W:0]   tail;
    logic [ROB_IDX_W-1:0] head_idx;
    logic [ROB_IDX_W-1:0] tail_idx;
    logic                 full;
    logic                 empty;
    logic                 alloc_fire;
    logic                 commit_fire;

    rob_entry_t           payload [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] done_q;
    logic [ROB_DEPTH-1:0] exc_q;

    assign head_idx = head[ROB_IDX_W-1:0];
    assign tail_idx = tail[ROB_IDX_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[ROB_IDX_W] != tail[ROB_IDX_W]);

    // Full is judged on registered state only: a same-cycle commit does not
    // open a slot for a same-cycle allocation. Flush overrides both.
    assign alloc_fire  = rob_if.entry_valid && !full && !rob_if.flush;
    assign commit_fire = rob_if.commit_valid && rob_if.commit_ready && !rob_if.flush;

    reorder_buffer_rob_ptr #(.IDX_W(ROB_IDX_W)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .clr (rob_if.flush),
        .inc (commit_fire),
        .ptr (head)
    );

    reorder_buffer_rob_ptr #(.IDX_W(ROB_IDX_W)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .clr (rob_if.flush),
        .inc (alloc_fire),
        .ptr (tail)
    );

    // Payload storage: written on allocation only.
    // NOTE: the payload array has no reset; valid_q guards every read that
    // matters, so resetting the storage would only cost flops.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            payload[tail_idx] <= rob_if.new_entry;
        end
    end

    // Per-entry valid/done/exception bits: writeback, retire, allocate.
    always_ff @(posedge clk) begin
        if (rst || rob_if.flush) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            // Writebacks to unallocated slots are dropped.
            if (rob_if.wb_valid && valid_q[rob_if.wb_index]) begin
                done_q[rob_if.wb_index] <= 1'b1;
                exc_q[rob_if.wb_index]  <= exc_q[rob_if.wb_index] | rob_if.wb_exception;
            end
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                exc_q[head_idx]   <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                exc_q[tail_idx]   <= 1'b0;
            end
        end
    end

    // Dispatch feedback and head offer, all from registered state.
    assign rob_if.rob_index        = tail_idx;
    assign rob_if.rob_full         = full;
    assign rob_if.commit_valid     = !empty && done_q[head_idx];
    assign rob_if.commit_entry     = payload[head_idx];
    assign rob_if.commit_index     = head_idx;
    assign rob_if.commit_exception = exc_q[head_idx];

`ifdef ROB_STATS_EN
    // Saturating occupancy/throughput counters; flush leaves them intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cycles <= '0;
            stat_commits     <= '0;
        end else begin
            if (full && rob_if.entry_valid && (stat_full_cycles != '1)) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
            if (commit_fire && (stat_commits != '1)) begin
                stat_commits <= stat_commits + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a constant-expectation vector
// table, directed multi-cycle sequences and randomized traffic, all compared
// against a queue-based model of in-order retirement.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    reorder_buffer_if #(.ROB_DEPTH(DEPTH)) rob_if ();

`ifdef ROB_STATS_EN
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_commits;
`endif

    reorder_buffer #(.ROB_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .rob_if (rob_if.slave)
`ifdef ROB_STATS_EN
        ,
        .stat_full_cycles (stat_full_cycles),
        .stat_commits     (stat_commits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: an ordered queue of live entries
    typedef struct {
        int         idx;
        rob_entry_t e;
        bit         done;
        bit         exc;
    } mentry_t;

    mentry_t mq[$];
    int      m_tail;

    // One cycle of stimulus, optionally with constant expectations.
    typedef struct {
        bit ev;
        bit wv;
        int wi;
        bit we;
        bit cr;
        bit fl;
        bit rs;
        bit has_exp;
        int exp_idx;
        bit exp_full;
        bit exp_cv;
        int exp_ci;
    } vec_t;

    function automatic vec_t v(bit ev, bit wv, int wi, bit we, bit cr, bit fl);
        vec_t r;
        r = '{ev: ev, wv: wv, wi: wi, we: we, cr: cr, fl: fl, rs: 1'b0,
              has_exp: 1'b0, exp_idx: 0, exp_full: 1'b0, exp_cv: 1'b0, exp_ci: 0};
        return r;
    endfunction

    function automatic vec_t vx(bit ev, bit wv, int wi, bit cr, int ei, bit ef, bit ecv, int eci);
        vec_t r;
        r = v(ev, wv, wi, 1'b0, cr, 1'b0);
        r.has_exp  = 1'b1;
        r.exp_idx  = ei;
        r.exp_full = ef;
        r.exp_cv   = ecv;
        r.exp_ci   = eci;
        return r;
    endfunction

    function automatic rob_entry_t rand_entry();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return rob_entry_t'(r[$bits(rob_entry_t)-1:0]);
    endfunction

    // Drive one cycle, compare pre-edge outputs, advance the model, clock.
    task automatic cycle(input vec_t s);
        rob_entry_t e;
        bit         m_full;
        bit         m_cv;
        e = rand_entry();
        rst                 = s.rs;
        rob_if.entry_valid  = s.ev;
        rob_if.new_entry    = e;
        rob_if.wb_valid     = s.wv;
        rob_if.wb_index     = 4'(s.wi);
        rob_if.wb_exception = s.we;
        rob_if.commit_ready = s.cr;
        rob_if.flush        = s.fl;
        #1;
        m_full = (mq.size() == DEPTH);
        m_cv   = (mq.size() > 0) && mq[0].done;
        check("rob_index", 64'(rob_if.rob_index), 64'(m_tail % DEPTH));
        check("rob_full", 64'(rob_if.rob_full), 64'(m_full));
        check("commit_valid", 64'(rob_if.commit_valid), 64'(m_cv));
        if (m_cv) begin
            check("commit_index", 64'(rob_if.commit_index), 64'(mq[0].idx));
            check("commit_entry", 64'(rob_if.commit_entry), 64'(mq[0].e));
            check("commit_exception", 64'(rob_if.commit_exception), 64'(mq[0].exc));
        end
        if (s.has_exp) begin
            check("tbl_rob_index", 64'(rob_if.rob_index), 64'(s.exp_idx));
            check("tbl_rob_full", 64'(rob_if.rob_full), 64'(s.exp_full));
            check("tbl_commit_valid", 64'(rob_if.commit_valid), 64'(s.exp_cv));
            if (s.exp_cv) begin
                check("tbl_commit_index", 64'(rob_if.commit_index), 64'(s.exp_ci));
            end
        end
        if (s.rs || s.fl) begin
            mq.delete();
            m_tail = 0;
        end else begin
            if (s.wv) begin
                foreach (mq[i]) begin
                    if (mq[i].idx == s.wi) begin
                        mq[i].done = 1'b1;
                        mq[i].exc  = mq[i].exc | s.we;
                    end
                end
            end
            if (m_cv && s.cr) begin
                void'(mq.pop_front());
            end
            if (s.ev && !m_full) begin
                mq.push_back('{idx: m_tail % DEPTH, e: e, done: 1'b0, exc: 1'b0});
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        rob_if.entry_valid  = 1'b0;
        rob_if.new_entry    = '0;
        rob_if.wb_valid     = 1'b0;
        rob_if.wb_index     = '0;
        rob_if.wb_exception = 1'b0;
        rob_if.commit_ready = 1'b0;
        rob_if.flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_tail = 0;
    endtask

    vec_t       tbl[13];
    rob_entry_t held_entry;
    logic [3:0] held_index;

    initial begin
        do_reset();

        // Reset state
        check("reset_rob_index", 64'(rob_if.rob_index), 64'd0);
        check("reset_rob_full", 64'(rob_if.rob_full), 64'd0);
        check("reset_commit_valid", 64'(rob_if.commit_valid), 64'd0);
        check("reset_commit_exception", 64'(rob_if.commit_exception), 64'd0);

        // Minimum latency, then out-of-order writeback with in-order retire.
        //            ev  wv wi cr  idx full cv ci
        tbl[0]  = vx(1, 0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = vx(0, 1, 0, 0,  1, 0, 0, 0);
        tbl[2]  = vx(0, 0, 0, 1,  1, 0, 1, 0);
        tbl[3]  = vx(1, 0, 0, 0,  1, 0, 0, 0);
        tbl[4]  = vx(1, 0, 0, 0,  2, 0, 0, 0);
        tbl[5]  = vx(1, 0, 0, 0,  3, 0, 0, 0);
        tbl[6]  = vx(0, 1, 3, 1,  4, 0, 0, 0);
        tbl[7]  = vx(0, 1, 2, 1,  4, 0, 0, 0);
        tbl[8]  = vx(0, 1, 1, 1,  4, 0, 0, 0);
        tbl[9]  = vx(0, 0, 0, 1,  4, 0, 1, 1);
        tbl[10] = vx(0, 0, 0, 1,  4, 0, 1, 2);
        tbl[11] = vx(0, 0, 0, 1,  4, 0, 1, 3);
        tbl[12] = vx(0, 0, 0, 1,  4, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i]);
        end

        // Fill to full; the 17th request is ignored and tail sits at index 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(v(1, 0, 0, 0, 0, 0));
        end
        check("fill_full", 64'(rob_if.rob_full), 64'd1);
        check("fill_tail_wrap", 64'(rob_if.rob_index), 64'd0);
        cycle(v(1, 0, 0, 0, 0, 0));
        check("overfill_full", 64'(rob_if.rob_full), 64'd1);
        check("overfill_tail", 64'(rob_if.rob_index), 64'd0);

        // Full ROB: commit and alloc in the same cycle -> alloc rejected.
        cycle(v(0, 1, 0, 0, 0, 0));
        cycle(v(1, 0, 0, 0, 1, 0));
        check("nobypass_full", 64'(rob_if.rob_full), 64'd0);
        check("nobypass_tail", 64'(rob_if.rob_index), 64'd0);
        cycle(v(1, 0, 0, 0, 0, 0));
        check("refill_full", 64'(rob_if.rob_full), 64'd1);
        check("refill_tail", 64'(rob_if.rob_index), 64'd1);

        // Flush mid-stream with pending writeback/commit/alloc.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(v(1, 0, 0, 0, 0, 0));
        end
        cycle(v(0, 1, 3, 1, 0, 0));
        cycle(v(0, 1, 0, 0, 0, 0));
        cycle(v(1, 1, 1, 0, 1, 1));
        check("flush_rob_index", 64'(rob_if.rob_index), 64'd0);
        check("flush_rob_full", 64'(rob_if.rob_full), 64'd0);
        check("flush_commit_valid", 64'(rob_if.commit_valid), 64'd0);
        cycle(v(0, 1, 0, 0, 1, 0));

        // Hold commit_ready low: head offer stays stable.
        do_reset();
        cycle(v(1, 0, 0, 0, 0, 0));
        cycle(v(0, 1, 0, 0, 0, 0));
        held_entry = rob_if.commit_entry;
        held_index = rob_if.commit_index;
        for (int i = 0; i < 3; i++) begin
            cycle(v(0, 0, 0, 0, 0, 0));
            check("hold_entry", 64'(rob_if.commit_entry), 64'(held_entry));
            check("hold_index", 64'(rob_if.commit_index), 64'(held_index));
        end
        cycle(v(0, 0, 0, 0, 1, 0));
        // 19 more allocations (20 total) streaming through wb/commit: wraps 15->0.
        for (int i = 1; i < 20; i++) begin
            cycle(v(1, 1, (i + DEPTH - 1) % DEPTH, 0, 1, 0));
        end
        check("wrap_tail", 64'(rob_if.rob_index), 64'd4);

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            vec_t s;
            int   wi;
            if ((mq.size() > 0) && ($urandom_range(1, 0) == 1)) begin
                wi = mq[$urandom_range(mq.size() - 1, 0)].idx;
            end else begin
                wi = $urandom_range(DEPTH - 1, 0);
            end
            s = v(($urandom % 4) != 0, ($urandom % 3) != 0, wi,
                  ($urandom % 6) == 0, ($urandom % 4) != 0, ($urandom % 97) == 0);
            s.rs = (($urandom % 251) == 0);
            cycle(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
